// File: rtl/mmio_uart_pkg.sv
// Shared register map, STATUS bit positions and TX state encoding for the
// memory-mapped UART transmitter.
package mmio_uart_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   localparam int unsigned STAT_FULL    = 0;
   localparam int unsigned STAT_EMPTY   = 1;
   localparam int unsigned STAT_BUSY    = 2;
   localparam int unsigned STAT_OVF     = 3;
   localparam int unsigned STAT_CNT_LSB = 4;

   localparam int unsigned CTRL_EN       = 0;
   localparam int unsigned WDATA_OVF_CLR = 3;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output; pushes when full and
// pops when empty are ignored, so count never exceeds DEPTH.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign full      = (r_count == (AW+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign dout      = r_mem[r_rd_ptr];
   assign w_push_ok = push & ~full;
   assign w_pop_ok  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= din;
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus: TXDATA pushes into
// a FIFO, STATUS/CTRL are read combinationally, tx is driven from a flop.
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        sel,
   output logic        tx
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   uart_tx_state_t r_state;
   logic [BW-1:0]  r_baud;
   logic [2:0]     r_bit;
   logic [7:0]     r_shift;
   logic           r_tx;
   logic           r_ovf;
   logic           r_en;

   logic           w_sel;
   logic [1:0]     w_off;
   logic           w_wr_txdata;
   logic           w_wr_status;
   logic           w_wr_ctrl;
   logic           w_ovf_set;
   logic           w_ovf_clr;
   logic           w_pop;
   logic           w_baud_done;
   logic           w_fifo_full;
   logic           w_fifo_empty;
   logic [CW-1:0]  w_fifo_count;
   logic [7:0]     w_fifo_dout;
   logic [31:0]    w_status;
   logic           w_unused_bits;

   assign w_sel       = (addr[31:4] == BASE_ADDR[31:4]);
   assign w_off       = addr[3:2];
   assign w_wr_txdata = we & w_sel & (w_off == OFF_TXDATA);
   assign w_wr_status = we & w_sel & (w_off == OFF_STATUS);
   assign w_wr_ctrl   = we & w_sel & (w_off == OFF_CTRL);
   assign w_ovf_set   = w_wr_txdata & w_fifo_full;
   assign w_ovf_clr   = w_wr_status & wdata[WDATA_OVF_CLR];
   assign w_pop       = (r_state == IDLE) & r_en & ~w_fifo_empty;
   assign w_baud_done = (r_baud == BAUD_LAST);
   assign w_unused_bits = ^{addr[1:0], wdata[31:8]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_wr_txdata),
      .pop   (w_pop),
      .din   (wdata[7:0]),
      .dout  (w_fifo_dout),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .count (w_fifo_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ovf <= 1'b0;
         r_en  <= 1'b1;
      end else begin
         if (w_ovf_set)      r_ovf <= 1'b1;
         else if (w_ovf_clr) r_ovf <= 1'b0;
         if (w_wr_ctrl)      r_en  <= wdata[CTRL_EN];
      end
   end

   // tx is registered alongside each state change, so it leads the state by no cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift <= w_fifo_dout;
                  r_baud  <= '0;
                  r_tx    <= 1'b0;
                  r_state <= START;
               end
            end
            START: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            DATA: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_shift <= r_shift >> 1;
                  if (r_bit == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bit <= r_bit + 1'b1;
                     r_tx  <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            STOP: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_state <= IDLE;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign tx  = r_tx;
   assign sel = w_sel;

   always_comb begin
      w_status = (32'(w_fifo_count) << STAT_CNT_LSB) & 32'h0000_00F0;
      w_status[STAT_FULL]  = w_fifo_full;
      w_status[STAT_EMPTY] = w_fifo_empty;
      w_status[STAT_BUSY]  = (r_state != IDLE);
      w_status[STAT_OVF]   = r_ovf;
   end

   always_comb begin
      rdata = '0;
      if (w_sel) begin
         case (w_off)
            OFF_STATUS: rdata = w_status;
            OFF_CTRL:   rdata = {31'b0, r_en};
            default:    rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a queue/frame-timer reference model predicts
// register reads and transmitted frames; a line monitor decodes tx independently.
module tb_mmio_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        sel;
   logic        tx;

   mmio_uart_tx #(
      .BASE_ADDR    (32'h0000_0100),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .sel   (sel),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] b;
      int         pcyc;
   } frame_t;

   logic [7:0] mq[$];
   frame_t     eq[$];
   int         mon_starts[$];
   bit         m_ovf   = 1'b0;
   bit         m_en    = 1'b1;
   int         m_timer = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      int n;
      n = mq.size();
      if (a[31:4] != 28'h000_0010) return 32'h0;
      case (a[3:2])
         2'd1: return {24'b0, 4'(n), m_ovf, (m_timer > 0), (n == 0), (n == DEPTH)};
         2'd2: return {31'b0, m_en};
         default: return 32'h0;
      endcase
   endfunction

   // Reference: the FIFO is a byte queue; a transmission occupies a whole-frame timer.
   task automatic model_step();
      int     pre;
      bit     do_pop, set, clr;
      frame_t fr;
      pre    = mq.size();
      do_pop = (m_timer == 0) && m_en && (pre > 0);
      set    = 1'b0;
      clr    = 1'b0;
      if (do_pop) begin
         fr.b    = mq.pop_front();
         fr.pcyc = cyc;
         eq.push_back(fr);
         m_timer = FRAME;
      end else if (m_timer > 0) begin
         m_timer--;
      end
      if (we && addr[31:4] == 28'h000_0010) begin
         case (addr[3:2])
            2'd0: if (pre < DEPTH) mq.push_back(wdata[7:0]); else set = 1'b1;
            2'd1: clr = wdata[3];
            2'd2: m_en = wdata[0];
            default: ;
         endcase
      end
      if (set)      m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            mq.delete();
            eq.delete();
            m_ovf   = 1'b0;
            m_en    = 1'b1;
            m_timer = 0;
         end else begin
            model_step();
         end
      end
   end

   logic mon_s [FRAME];
   bit   mon_act = 1'b0;
   int   mon_n   = 0;
   int   mon_t   = 0;

   task automatic mon_check();
      bit         shape_ok;
      logic [7:0] b;
      frame_t     fr;
      shape_ok = 1'b1;
      for (int k = 0; k < 10; k++)
         for (int j = 0; j < CPB; j++)
            if (mon_s[k*CPB+j] !== mon_s[k*CPB]) shape_ok = 1'b0;
      if (mon_s[0] !== 1'b0 || mon_s[9*CPB] !== 1'b1) shape_ok = 1'b0;
      for (int i = 0; i < 8; i++) b[i] = mon_s[(i+1)*CPB];
      chk("frame_shape", 32'(shape_ok), 32'd1);
      mon_starts.push_back(mon_t);
      if (eq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL frame_unexpected: got byte %h expected no frame (cycle %0d)", b, cyc);
      end else begin
         fr = eq.pop_front();
         chk("frame_byte", 32'(b), 32'(fr.b));
         chk("frame_start", mon_t, fr.pcyc + 1);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_act = 1'b0;
         end else begin
            if (!mon_act && tx === 1'b0) begin
               mon_act = 1'b1;
               mon_n   = 0;
               mon_t   = cyc;
            end
            if (mon_act) begin
               mon_s[mon_n] = tx;
               mon_n++;
               if (mon_n == FRAME) begin
                  mon_act = 1'b0;
                  mon_check();
               end
            end
         end
      end
   end

   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      we    = w;
      addr  = a;
      wdata = d;
      #1;
      chk("sel", 32'(sel), 32'(a[31:4] == 28'h000_0010));
      chk("rdata", rdata, m_read(a));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         bus(1'b0, 32'h100 | 32'($urandom_range(0, 15)), $urandom);
   endtask

   task automatic read_status(input logic [31:0] exp, input string name);
      bus(1'b0, 32'h104, 32'h0);
      chk(name, rdata, exp);
   endtask

   int a5_pat [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
   int lows;
   int waited;
   int r;

   initial begin
      reset = 1'b1;
      we    = 1'b0;
      addr  = 32'h104;
      wdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_status", rdata, 32'h2);
      @(negedge clk);
      #1 reset = 1'b0;

      // Reset state and decode
      read_status(32'h2, "status_after_reset");
      chk("sel_104", 32'(sel), 32'd1);
      bus(1'b0, 32'h60, 32'h0);
      chk("sel_60", 32'(sel), 32'd0);
      bus(1'b0, 32'h108, 32'h0);
      chk("ctrl_reset", rdata, 32'h1);

      // Single frame 0xA5 with explicit bit pattern
      bus(1'b1, 32'h100, 32'hA5);
      idle(1);
      chk("a5_pre_edge_tx", 32'(tx), 32'd1);
      for (int k = 0; k < 10; k++)
         for (int j = 0; j < CPB; j++) begin
            bus(1'b0, 32'h104, 32'h0);
            chk("a5_bit", 32'(tx), 32'(a5_pat[k]));
            chk("a5_busy", 32'(rdata[2]), 32'd1);
         end
      read_status(32'h2, "status_after_a5");

      // Overflow with EN=0
      bus(1'b1, 32'h108, 32'h0);
      for (int k = 1; k <= 6; k++) bus(1'b1, 32'h100, 32'(k));
      read_status(32'h49, "status_overflow");
      bus(1'b1, 32'h104, 32'h8);
      read_status(32'h41, "status_ovf_cleared");

      // Drain 01..04 in order, 41 cycles apart
      mon_starts.delete();
      bus(1'b1, 32'h108, 32'h1);
      idle(4 * (FRAME + 1) + 6);
      chk("drain_frames", mon_starts.size(), 32'd4);
      for (int i = 1; i < mon_starts.size(); i++)
         chk("drain_spacing", mon_starts[i] - mon_starts[i-1], FRAME + 1);
      read_status(32'h2, "status_drained");

      // Push in the pop cycle with count=1
      bus(1'b1, 32'h108, 32'h0);
      bus(1'b1, 32'h100, 32'($urandom_range(0, 255)));
      bus(1'b1, 32'h108, 32'h1);
      bus(1'b1, 32'h100, 32'($urandom_range(0, 255)));
      read_status(32'h14, "status_push_pop");
      idle(2 * (FRAME + 1) + 6);
      read_status(32'h2, "status_push_pop_drained");

      // Push into a full FIFO in the pop cycle is dropped
      bus(1'b1, 32'h108, 32'h0);
      for (int k = 0; k < 4; k++) bus(1'b1, 32'h100, 32'($urandom_range(0, 255)));
      bus(1'b1, 32'h108, 32'h1);
      bus(1'b1, 32'h100, 32'h5A);
      read_status(32'h3C, "status_full_pop_drop");
      bus(1'b1, 32'h104, 32'h8);
      read_status(32'h34, "status_full_pop_clr");
      idle(4 * (FRAME + 1) + 6);
      read_status(32'h2, "status_full_pop_drained");

      // Reset during data bit 3
      bus(1'b1, 32'h100, 32'($urandom_range(0, 255)));
      idle(18);
      addr  = 32'h104;
      we    = 1'b0;
      reset = 1'b1;
      #1;
      chk("midframe_reset_tx", 32'(tx), 32'd1);
      chk("midframe_reset_status", rdata, 32'h2);
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      read_status(32'h2, "status_after_midframe_reset");
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         idle(1);
         if (tx !== 1'b1) lows++;
      end
      chk("no_frame_after_reset", lows, 0);

      // Randomised traffic against the model
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: bus(1'b1, 32'h100 | 32'($urandom_range(0, 3)), $urandom);
            3:       bus(1'b1, 32'h108 | 32'($urandom_range(0, 3)),
                         32'($urandom_range(0, 3) != 0) | ($urandom & 32'hFFFF_FFFE));
            4:       bus(1'b1, 32'h104 | 32'($urandom_range(0, 3)), $urandom);
            5:       bus(1'b1, 32'h10C | 32'($urandom_range(0, 3)), $urandom);
            6:       bus(1'b1, (32'h110 + 32'($urandom_range(0, 255))) | 32'h100, $urandom);
            7:       bus(1'b0, $urandom, $urandom);
            default: idle(1);
         endcase
      end
      bus(1'b1, 32'h108, 32'h1);
      waited = 0;
      while (!(mq.size() == 0 && m_timer == 0 && eq.size() == 0) && waited < 1000) begin
         idle(1);
         waited++;
      end
      chk("random_drain_in_time", 32'(waited < 1000), 32'd1);
      bus(1'b1, 32'h104, 32'h8);
      read_status(32'h2, "status_final");
      idle(2);
      chk("scoreboard_empty", eq.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
